scoreboard_input_conditioner: RTL

Front-end conditioner for the basketball scoreboard: synchronizes and debounces the raw Nexys A7 push-buttons and switches, then turns them into the clean control signals consumed by the seven-segment scoreboard/timer controller. Outputs are `one_point`, `two_point`, `three_point`, `team`, `pause`, `reset_points` and `reset_score`. Point and reset events are stretched to a programmable width so that the controller's slow-clock score logic cannot miss them. The block sits directly upstream of the display controller; it shares the 100 MHz board clock and the active-low board reset.

---
 rtl/scoreboard_input_conditioner.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/scoreboard_input_conditioner.sv
// scoreboard_input_conditioner
// Synchronizes and debounces the raw scoreboard buttons. It converts presses
// into stretched point/reset pulses and into team/pause levels for the
// seven-segment scoreboard controller.
// Optional feature macro: SB_PAUSE_TOGGLE_EN. When it is defined, pause toggles
// on each press. When it is undefined, pause follows the debounced button level.
module scoreboard_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned PULSE_LEN       = 2_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_one,
  input  logic btn_two,
  input  logic btn_three,
  input  logic btn_team,
  input  logic btn_pause,
  input  logic btn_clr_pts,
  input  logic btn_clr_time,
  output logic one_point,
  output logic two_point,
  output logic three_point,
  output logic team,
  output logic pause,
  output logic reset_points,
  output logic reset_score
);

  localparam int unsigned NB        = 7;
  localparam int unsigned I_ONE     = 0;
  localparam int unsigned I_TWO     = 1;
  localparam int unsigned I_THREE   = 2;
  localparam int unsigned I_TEAM    = 3;
  localparam int unsigned I_PAUSE   = 4;
  localparam int unsigned I_CLR_PTS = 5;
  localparam int unsigned I_CLR_TIM = 6;

  localparam int unsigned DCW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PCW = $clog2(PULSE_LEN + 1);

  localparam logic [DCW-1:0] DB_LAST    = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DCW-1:0] DB_ONE     = DCW'(1);
  localparam logic [PCW-1:0] PULSE_LOAD = PCW'(PULSE_LEN);
  localparam logic [PCW-1:0] PULSE_ONE  = PCW'(1);

  typedef enum logic {
    PT_IDLE,
    PT_PULSE
  } pt_state_e;

  logic [NB-1:0]  raw;
  logic [NB-1:0]  sync1_q, sync1_d;
  logic [NB-1:0]  sync2_q, sync2_d;
  logic [NB-1:0]  stable_q, stable_d;
  logic [NB-1:0]  ev_q, ev_d;
  logic [DCW-1:0] db_cnt_q [NB];
  logic [DCW-1:0] db_cnt_d [NB];

  pt_state_e      pt_state_q, pt_state_d;
  logic [PCW-1:0] pt_cnt_q, pt_cnt_d;
  logic           one_q, one_d;
  logic           two_q, two_d;
  logic           three_q, three_d;
  logic           team_q, team_d;
  logic           team_pending_q, team_pending_d;
  logic           pt_accept;

  logic [PCW-1:0] rp_cnt_q, rp_cnt_d;
  logic [PCW-1:0] rs_cnt_q, rs_cnt_d;
  logic           rp_q, rp_d;
  logic           rs_q, rs_d;

  assign raw = {btn_clr_time, btn_clr_pts, btn_pause, btn_team,
                btn_three, btn_two, btn_one};

  // Synchronizer stages and per-input debounce rule with rising-edge detect
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    for (int unsigned i = 0; i < NB; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
        end
      end
    end
    ev_d = stable_d & ~stable_q;
  end

  // Input path registers: synchronizers, debounce state and event flops
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      ev_q     <= '0;
      for (int unsigned i = 0; i < NB; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      ev_q     <= ev_d;
      for (int unsigned i = 0; i < NB; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // Score-clear and time-reset stretchers; output is high while the count is non-zero
  always_comb begin
    rp_cnt_d = rp_cnt_q;
    if (rp_cnt_q == '0) begin
      if (ev_q[I_CLR_PTS]) rp_cnt_d = PULSE_LOAD;
    end else begin
      rp_cnt_d = rp_cnt_q - PULSE_ONE;
    end
    rs_cnt_d = rs_cnt_q;
    if (rs_cnt_q == '0) begin
      if (ev_q[I_CLR_TIM]) rs_cnt_d = PULSE_LOAD;
    end else begin
      rs_cnt_d = rs_cnt_q - PULSE_ONE;
    end
    rp_d = (rp_cnt_d != '0);
    rs_d = (rs_cnt_d != '0);
  end

  // Reset-pulse registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rp_cnt_q <= '0;
      rs_cnt_q <= '0;
      rp_q     <= 1'b0;
      rs_q     <= 1'b0;
    end else begin
      rp_cnt_q <= rp_cnt_d;
      rs_cnt_q <= rs_cnt_d;
      rp_q     <= rp_d;
      rs_q     <= rs_d;
    end
  end

  // Point FSM next state, priority select, clear override and deferred team toggle
  always_comb begin
    pt_state_d     = pt_state_q;
    pt_cnt_d       = pt_cnt_q;
    one_d          = one_q;
    two_d          = two_q;
    three_d        = three_q;
    team_d         = team_q;
    team_pending_d = team_pending_q;
    pt_accept      = (ev_q[I_ONE] | ev_q[I_TWO] | ev_q[I_THREE]) &
                     ~ev_q[I_CLR_PTS] & ~rp_q;

    case (pt_state_q)
      PT_IDLE: begin
        if (pt_accept) begin
          pt_state_d = PT_PULSE;
          pt_cnt_d   = PULSE_LOAD;
          three_d    = ev_q[I_THREE];
          two_d      = ev_q[I_TWO] & ~ev_q[I_THREE];
          one_d      = ev_q[I_ONE] & ~ev_q[I_TWO] & ~ev_q[I_THREE];
        end
      end
      PT_PULSE: begin
        if (pt_cnt_q == PULSE_ONE) begin
          pt_state_d = PT_IDLE;
          pt_cnt_d   = '0;
          one_d      = 1'b0;
          two_d      = 1'b0;
          three_d    = 1'b0;
        end else begin
          pt_cnt_d = pt_cnt_q - PULSE_ONE;
        end
      end
      default: begin
        pt_state_d = PT_IDLE;
        pt_cnt_d   = '0;
        one_d      = 1'b0;
        two_d      = 1'b0;
        three_d    = 1'b0;
      end
    endcase

    if (ev_q[I_CLR_PTS]) begin
      pt_state_d = PT_IDLE;
      pt_cnt_d   = '0;
      one_d      = 1'b0;
      two_d      = 1'b0;
      three_d    = 1'b0;
    end

    // In IDLE, a pending toggle and a fresh event cancel each other, as they do in PULSE
    if (pt_state_q == PT_IDLE) begin
      team_d         = team_q ^ team_pending_q ^ ev_q[I_TEAM];
      team_pending_d = 1'b0;
    end else begin
      team_pending_d = team_pending_q ^ ev_q[I_TEAM];
    end
  end

  // Point FSM state, counter and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pt_state_q     <= PT_IDLE;
      pt_cnt_q       <= '0;
      one_q          <= 1'b0;
      two_q          <= 1'b0;
      three_q        <= 1'b0;
      team_q         <= 1'b0;
      team_pending_q <= 1'b0;
    end else begin
      pt_state_q     <= pt_state_d;
      pt_cnt_q       <= pt_cnt_d;
      one_q          <= one_d;
      two_q          <= two_d;
      three_q        <= three_d;
      team_q         <= team_d;
      team_pending_q <= team_pending_d;
    end
  end

`ifdef SB_PAUSE_TOGGLE_EN
  logic pause_q, pause_d;

  // Pause toggles on every debounced press
  always_comb begin
    pause_d = pause_q ^ ev_q[I_PAUSE];
  end

  // Pause toggle register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pause_q <= 1'b0;
    else        pause_q <= pause_d;
  end

  assign pause = pause_q;
`else
  logic pause_ev_unused;
  assign pause_ev_unused = ev_q[I_PAUSE];
  assign pause           = stable_q[I_PAUSE];
`endif

  assign one_point    = one_q;
  assign two_point    = two_q;
  assign three_point  = three_q;
  assign team         = team_q;
  assign reset_points = rp_q;
  assign reset_score  = rs_q;

endmodule
